// File: rtl/sdr_rom_arbiter.sv
// Round-robin arbiter sharing one 64-bit SDRAM read port among NUM_PORTS ROM clients.
// Optional macro SDR_ARB_PORT0_PRIORITY_EN: port 0 always wins and does not move the rotation pointer.
module sdr_rom_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    req,
   input  logic [NUM_PORTS*25-1:0] addr,
   output logic [NUM_PORTS-1:0]    ack,
   output logic [63:0]             rd_data,
   output logic [24:0]             sdr_addr,
   output logic                    sdr_req,
   input  logic [63:0]             sdr_data,
   input  logic                    sdr_rdy,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t                 state_q;
   logic [PTR_W-1:0]       rr_ptr_q;
   logic [PTR_W-1:0]       grant_q;
   logic [7:0]             cnt_q;
   logic [NUM_PORTS-1:0]   ack_q;
   logic [63:0]            rd_data_q;
   logic [24:0]            sdr_addr_q;
   logic                   sdr_req_q;
   logic                   busy_q;
   logic                   timeout_err_q;

   // Only the 8-byte line address matters; the low byte-offset bits are dropped.
   logic [21:0]            port_addr [NUM_PORTS];
   logic [NUM_PORTS-1:0][2:0] addr_lsbs_unused;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
         assign port_addr[gi]        = addr[25*gi+3 +: 22];
         assign addr_lsbs_unused[gi] = addr[25*gi +: 3];
      end
   endgenerate

   logic             grant_valid;
   logic [PTR_W-1:0] grant_sel;
   logic [PTR_W:0]   scan_idx;

   // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = '0;
      scan_idx    = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_idx >= (PTR_W+1)'(NUM_PORTS)) begin
            scan_idx = scan_idx - (PTR_W+1)'(NUM_PORTS);
         end
         if (req[scan_idx[PTR_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_sel   = scan_idx[PTR_W-1:0];
         end
      end
`ifdef SDR_ARB_PORT0_PRIORITY_EN
      if (req[0]) begin
         grant_valid = 1'b1;
         grant_sel   = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= PTR_W'(NUM_PORTS-1);
         grant_q       <= '0;
         cnt_q         <= '0;
         ack_q         <= '0;
         rd_data_q     <= '0;
         sdr_addr_q    <= '0;
         sdr_req_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         sdr_req_q <= 1'b0;
         ack_q     <= '0;
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  grant_q    <= grant_sel;
                  sdr_addr_q <= {port_addr[grant_sel], 3'b000};
`ifdef SDR_ARB_PORT0_PRIORITY_EN
                  if (grant_sel != '0) begin
                     rr_ptr_q <= grant_sel;
                  end
`else
                  rr_ptr_q   <= grant_sel;
`endif
                  sdr_req_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // Completion beats a coincident timeout.
               if (sdr_rdy) begin
                  rd_data_q      <= sdr_data;
                  ack_q[grant_q] <= 1'b1;
                  state_q        <= ACK;
               end else if (cnt_q == 8'(TIMEOUT)) begin
                  timeout_err_q <= 1'b1;
                  sdr_req_q     <= 1'b1;
                  state_q       <= ISSUE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ACK: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_q;
   assign rd_data     = rd_data_q;
   assign sdr_addr    = sdr_addr_q;
   assign sdr_req     = sdr_req_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdr_rom_arbiter.sv
// Directed bench for sdr_rom_arbiter (4 ports, TIMEOUT=16), acting as clients and SDRAM controller.
module tb_sdr_rom_arbiter;

   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NP-1:0] req = '0;
   logic [NP*25-1:0] addr = '0;
   logic [NP-1:0] ack;
   logic [63:0]   rd_data;
   logic [24:0]   sdr_addr;
   logic          sdr_req;
   logic [63:0]   sdr_data = '0;
   logic          sdr_rdy = 1'b0;
   logic          busy;
   logic          timeout_err;

   int checks = 0;
   int failures = 0;

   sdr_rom_arbiter #(.NUM_PORTS(NP), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .ack(ack),
      .rd_data(rd_data), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
      .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          port;
      logic [24:0] a;
      int          delay;
      logic [63:0] d;
      logic [24:0] exp_addr;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      sdr_rdy = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Waits (bounded) for an sdr_req pulse, answers after 'delay' cycles, returns what the ACK cycle shows.
   task automatic serve(input int delay, input logic [63:0] d,
                        output logic [24:0] got_addr, output int nreq,
                        output logic [NP-1:0] ack_v, output logic [63:0] rd_v);
      int t = 0;
      nreq = 0;
      got_addr = '0;
      ack_v = '0;
      rd_v = '0;
      while (sdr_req !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sdr_req !== 1'b1) begin
         chk("sdr_req_wait", {63'd0, sdr_req}, 64'd1);
         return;
      end
      nreq = 1;
      got_addr = sdr_addr;
      for (int i = 1; i <= delay; i++) begin
         @(negedge clk);
         if (sdr_req === 1'b1) nreq++;
      end
      sdr_rdy  = 1'b1;
      sdr_data = d;
      @(negedge clk);
      sdr_rdy  = 1'b0;
      sdr_data = '0;
      if (sdr_req === 1'b1) nreq++;
      ack_v = ack;
      rd_v  = rd_data;
   endtask

   logic [24:0]   g_addr;
   int            g_nreq;
   logic [NP-1:0] g_ack;
   logic [63:0]   g_rd;
   int            rr_exp[6] = '{0, 1, 2, 3, 0, 1};
   int            extra;

   initial begin
      vecs[0] = '{2, 25'h0123457, 3, 64'hDEADBEEF_CAFEF00D, 25'h0123450};
      vecs[1] = '{0, 25'h1FFFFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 25'h1FFFFF8};
      vecs[2] = '{3, 25'h0000008, 5, 64'h01234567_89ABCDEF, 25'h0000008};
      vecs[3] = '{1, 25'h0000007, 2, 64'h0, 25'h0000000};
      vecs[4] = '{2, 25'h1555555, 4, 64'hA5A5A5A5_5A5A5A5A, 25'h1555550};

      apply_reset();
      chk("rst_ack", {60'd0, ack}, 64'd0);
      chk("rst_sdr_req", {63'd0, sdr_req}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
      chk("rst_sdr_addr", {39'd0, sdr_addr}, 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);

      // All ports requesting continuously: strict rotation starting at port 0.
      for (int p = 0; p < NP; p++) addr[25*p +: 25] = 25'(32'h100 * (p + 1));
      req = '1;
      for (int i = 0; i < 6; i++) begin
         serve(1, 64'h1000 + 64'(i), g_addr, g_nreq, g_ack, g_rd);
         $display("rr txn %0d: ack=%b addr=%h", i, g_ack, g_addr);
         chk("rr_grant", {60'd0, g_ack}, 64'(1 << rr_exp[i]));
         chk("rr_addr", {39'd0, g_addr}, 64'(32'h100 * (rr_exp[i] + 1)));
         chk("rr_data", g_rd, 64'h1000 + 64'(i));
      end
      req = '0;
      repeat (3) @(negedge clk);

      // Single-requester vectors.
      for (int v = 0; v < 5; v++) begin
         addr[25*vecs[v].port +: 25] = vecs[v].a;
         req[vecs[v].port] = 1'b1;
         serve(vecs[v].delay, vecs[v].d, g_addr, g_nreq, g_ack, g_rd);
         req = '0;
         $display("vec txn %0d: port=%0d sdr_addr=%h ack=%b rd_data=%h", v, vecs[v].port, g_addr, g_ack, g_rd);
         chk("vec_sdr_addr", {39'd0, g_addr}, {39'd0, vecs[v].exp_addr});
         chk("vec_nreq", 64'(g_nreq), 64'd1);
         chk("vec_ack", {60'd0, g_ack}, 64'(1 << vecs[v].port));
         chk("vec_rd_data", g_rd, vecs[v].d);
         @(negedge clk);
         chk("vec_ack_clear", {60'd0, ack}, 64'd0);
         chk("vec_rd_hold", rd_data, vecs[v].d);
      end

      // sdr_rdy while idle is ignored.
      @(negedge clk);
      sdr_rdy = 1'b1;
      sdr_data = 64'h1111_2222_3333_4444;
      @(negedge clk);
      sdr_rdy = 1'b0;
      $display("idle rdy txn: ack=%b rd_data=%h busy=%b", ack, rd_data, busy);
      chk("idle_rdy_ack", {60'd0, ack}, 64'd0);
      chk("idle_rdy_rd_data", rd_data, vecs[4].d);
      chk("idle_rdy_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("idle_rdy_sdr_req", {63'd0, sdr_req}, 64'd0);

      // sdr_rdy on the same cycle the counter hits TIMEOUT: completion wins.
      apply_reset();
      addr[0 +: 25] = 25'h0ABCDE8;
      req = 4'b0001;
      serve(17, 64'h5555_AAAA_5555_AAAA, g_addr, g_nreq, g_ack, g_rd);
      req = '0;
      $display("coincident txn: ack=%b nreq=%0d timeout_err=%b", g_ack, g_nreq, timeout_err);
      chk("coin_ack", {60'd0, g_ack}, 64'd1);
      chk("coin_nreq", 64'(g_nreq), 64'd1);
      chk("coin_timeout_err", {63'd0, timeout_err}, 64'd0);
      @(negedge clk);
      chk("coin_no_reissue", {63'd0, sdr_req}, 64'd0);
      chk("coin_ack_clear", {60'd0, ack}, 64'd0);

      // Withheld sdr_rdy: re-issue 17 cycles after WAIT entry, sticky error.
      addr[50 +: 25] = 25'h0777771;
      req = 4'b0100;
      extra = 0;
      for (int t = 0; t < 100 && sdr_req !== 1'b1; t++) @(negedge clk);
      chk("to_first_req", {63'd0, sdr_req}, 64'd1);
      for (int off = 1; off <= 17; off++) begin
         @(negedge clk);
         if (sdr_req === 1'b1) extra++;
      end
      chk("to_no_early_req", 64'(extra), 64'd0);
      chk("to_err_before", {63'd0, timeout_err}, 64'd0);
      @(negedge clk);
      chk("to_reissue", {63'd0, sdr_req}, 64'd1);
      chk("to_err_set", {63'd0, timeout_err}, 64'd1);
      chk("to_same_addr", {39'd0, sdr_addr}, 64'h0777770);
      serve(2, 64'hCAFE_0000_BEEF_0001, g_addr, g_nreq, g_ack, g_rd);
      req = '0;
      $display("timeout txn: ack=%b rd_data=%h timeout_err=%b", g_ack, g_rd, timeout_err);
      chk("to_ack", {60'd0, g_ack}, 64'b0100);
      chk("to_rd_data", g_rd, 64'hCAFE_0000_BEEF_0001);
      chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);

      // Reset in WAIT abandons the transfer; rotation restarts at port 0.
      @(negedge clk);
      addr[25 +: 25] = 25'h0000101;
      addr[75 +: 25] = 25'h0000303;
      req = 4'b0010;
      for (int t = 0; t < 100 && sdr_req !== 1'b1; t++) @(negedge clk);
      chk("rst_wait_req", {63'd0, sdr_req}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      $display("reset-in-wait txn: busy=%b sdr_req=%b ack=%b", busy, sdr_req, ack);
      chk("rstw_busy", {63'd0, busy}, 64'd0);
      chk("rstw_sdr_req", {63'd0, sdr_req}, 64'd0);
      chk("rstw_ack", {60'd0, ack}, 64'd0);
      chk("rstw_timeout_err", {63'd0, timeout_err}, 64'd0);
      reset = 1'b0;
      req = 4'b1010;
      serve(1, 64'h11, g_addr, g_nreq, g_ack, g_rd);
      req[1] = 1'b0;
      $display("post-reset txn: ack=%b sdr_addr=%h", g_ack, g_addr);
      chk("rstw_first_grant", {60'd0, g_ack}, 64'b0010);
      chk("rstw_first_addr", {39'd0, g_addr}, 64'h0000100);
      serve(1, 64'h33, g_addr, g_nreq, g_ack, g_rd);
      req = '0;
      $display("post-reset txn: ack=%b sdr_addr=%h", g_ack, g_addr);
      chk("rstw_second_grant", {60'd0, g_ack}, 64'b1000);
      chk("rstw_second_addr", {39'd0, g_addr}, 64'h0000300);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdr_rom_arbiter.md
Name: sdr_rom_arbiter

Overview:
Shares the single 64-bit SDRAM read port between NUM_PORTS ROM clients, such as the CPU ROM cache, sprite fetch, tile fetch and sound ROM. Each client raises a level request with a 25-bit byte address. The arbiter grants one client at a time in round-robin order, issues a one-cycle sdr_req, waits for sdr_rdy, and returns the 64-bit line with a one-cycle ack to the granted client. It sits between the per-region ROM caches and the SDRAM controller.

Parameters:
NUM_PORTS, 4, number of requesting clients (2..8).
TIMEOUT, 255, cycles to wait for sdr_rdy before re-issuing sdr_req (8-bit counter; must be ≥ 16).

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_PORTS  per-client read request, level, held until ack.
addr  in  NUM_PORTS*25  per-client byte address, port i at [25*i+24:25*i]; stable while req[i] high.
ack  out  NUM_PORTS  one-cycle pulse to the granted client; rd_data valid that cycle.
rd_data  out  64  returned line; held until the next ack.
sdr_addr  out  25  address to the SDRAM controller; bits [2:0] forced to 0.
sdr_req  out  1  one-cycle issue strobe.
sdr_data  in  64  SDRAM read data, valid with sdr_rdy.
sdr_rdy  in  1  one-cycle completion strobe.
busy  out  1  high in ISSUE/WAIT/ACK.
timeout_err  out  1  sticky; set on any timeout; cleared only by reset.

Behaviour:
- Reset values:
  - state = IDLE; ack = 0; sdr_req = 0; busy = 0; timeout_err = 0.
  - sdr_addr = 0; rd_data = 0.
  - rr_ptr = NUM_PORTS-1, so port 0 wins first.
  - Timeout counter = 0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr+1, rr_ptr+2, … with wrap-around modulo NUM_PORTS.
  - Latch grant, then latch sdr_addr = {addr[grant][24:3], 3'b000}.
  - Set rr_ptr = grant and go to ISSUE.
  - If no req bit is set, remain in IDLE.
- ISSUE: sdr_req = 1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - On sdr_rdy: capture rd_data <= sdr_data and go to ACK.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT: set timeout_err and go to ISSUE. This re-issues the same sdr_addr; retries are unlimited.
- ACK: ack[grant] = 1 for exactly this cycle; go to IDLE.
- Client rule: deassert req or change addr no earlier than the cycle after ack.
  - The arbiter does not sample req in ACK.
  - The IDLE cycle after ACK may re-grant the same port only if it is the sole requester.
- Latency: req sampled in IDLE at cycle T gives sdr_req at T+1. sdr_rdy at cycle R gives ack at R+1. Minimum turnaround is 4 cycles (rdy in the first WAIT cycle).
- sdr_addr is stable from ISSUE until leaving ACK.
- sdr_rdy outside WAIT is ignored: no capture, no ack.
- Simultaneous sdr_rdy and counter==TIMEOUT: sdr_rdy wins; no retry, no error.
- req[i] dropping while port i is granted (protocol violation): the transaction still completes and ack still pulses.
- Reset mid-operation: all state returns to reset values the next cycle; the in-flight transaction is abandoned with no ack. The SDRAM controller shares this reset.

Optional Feature:
SDR_ARB_PORT0_PRIORITY_EN.
- Defined: in IDLE, req[0] always wins over round-robin and rr_ptr is not updated on a port-0 grant. This gives the CPU ROM cache lowest latency. Other ports rotate round-robin among themselves.
- Undefined: pure round-robin across all ports, as described in Behaviour.

Test Plan:
- Single port 2, addr 0x0123457, sdr_rdy 3 cycles after sdr_req, sdr_data 0xDEADBEEF_CAFEF00D -> sdr_addr 0x0123450, one sdr_req, ack[2] 1 cycle after rdy, rd_data matches, no other ack bits.
- All 4 ports request continuously, rdy after 1 cycle -> grants 0,1,2,3,0,1; each ack exactly once per grant. With SDR_ARB_PORT0_PRIORITY_EN and port 0 re-requesting, grants are 0,1,0,2,0,3.
- sdr_rdy withheld, TIMEOUT=16 -> sdr_req re-pulses 17 cycles after the first WAIT entry; timeout_err = 1; a later rdy completes with ack; timeout_err stays 1.
- sdr_rdy pulsed while IDLE, no req pending -> rd_data unchanged, no ack, state stays IDLE.
- reset asserted in WAIT for port 1 -> next cycle busy=0, sdr_req=0, no ack[1]; after release with req[1] and req[3] both high, port 0 is not requesting so port 1 is granted first.
- sdr_rdy coincident with counter==TIMEOUT -> ack issued, no second sdr_req, timeout_err stays 0.
